// File: rtl/gcd_result_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : gcd_result_fifo
//  Description : Result capture FIFO behind the GCD unit. Absorbs one-cycle
//                result strobes that cannot be stalled and re-presents them
//                on a valid/ready stream. Results arriving while the FIFO is
//                full and not draining are dropped and flagged through a
//                sticky overflow bit.
//  Revision    : 1.0 - initial release
// ============================================================================
module gcd_result_fifo #(
  parameter int DEPTH      = 4,
  parameter int DATA_WIDTH = 16,
  parameter int CW         = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  io_in_valid,
  input  logic [DATA_WIDTH-1:0] io_in_data,
  output logic                  io_out_valid,
  input  logic                  io_out_ready,
  output logic [DATA_WIDTH-1:0] io_out_data,
  output logic [CW-1:0]         io_count,
  output logic                  io_full,
  output logic                  io_overflow,
  input  logic                  io_clear_overflow
);

  // Pointer width; DEPTH is a power of two so pointers wrap naturally.
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  // Reset release register: asserts with the external reset, releases on the
  // first clock edge after deassertion, so the FIFO state logic accepts its
  // first push on the second edge after release.
  logic rst_sync_q;
  logic rst_sync_d;

  // FIFO state
  logic [PW-1:0]         wr_ptr_q,   wr_ptr_d;
  logic [PW-1:0]         rd_ptr_q,   rd_ptr_d;
  logic [CW-1:0]         count_q,    count_d;
  logic                  overflow_q, overflow_d;

  // Storage is deliberately left without reset; count qualifies its contents.
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  // Handshake decode
  logic w_full;
  logic w_not_empty;
  logic w_pop;
  logic w_push;
  logic w_drop;

  // Reset release value: always heads towards "running".
  always_comb begin
    rst_sync_d = 1'b1;
  end

  // Reset release register, asserted asynchronously by the external reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rst_sync_q <= 1'b0;
    end else begin
      rst_sync_q <= rst_sync_d;
    end
  end

  // Status decode purely from registered count; no input reaches an output.
  always_comb begin
    w_full      = (count_q == CW'(DEPTH));
    w_not_empty = (count_q != '0);
  end

  // Push/pop/drop decisions. A pop frees a slot in the same cycle, so a full
  // FIFO that is draining still accepts the incoming result.
  always_comb begin
    w_pop  = rst_sync_q & w_not_empty & io_out_ready;
    w_push = rst_sync_q & io_in_valid & (~w_full | w_pop);
    w_drop = rst_sync_q & io_in_valid & w_full & ~w_pop;
  end

  // Next-state for pointers, occupancy and the sticky overflow flag.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q + CW'(w_push) - CW'(w_pop);
    overflow_d = overflow_q;

    if (w_push) begin
      wr_ptr_d = wr_ptr_q + PW'(1);
    end
    if (w_pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end

    // A drop in the same cycle as a clear request keeps the flag set.
    if (w_drop) begin
      overflow_d = 1'b1;
    end else if (io_clear_overflow) begin
      overflow_d = 1'b0;
    end
  end

  // FIFO control registers; cleared immediately when reset asserts.
  always_ff @(posedge clk or negedge rst_sync_q) begin
    if (!rst_sync_q) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // Result storage write; the incoming value is kept verbatim, zero included.
  always_ff @(posedge clk) begin
    if (w_push) begin
      mem_q[wr_ptr_q] <= io_in_data;
    end
  end

  // Output drive from registered state.
  always_comb begin
    io_out_valid = w_not_empty;
    io_out_data  = mem_q[rd_ptr_q];
    io_count     = count_q;
    io_full      = w_full;
    io_overflow  = overflow_q;
  end

endmodule
`default_nettype wire

// File: tb/tb_gcd_result_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : tb_gcd_result_fifo
//  Description : Self-checking bench for gcd_result_fifo. A queue-based model
//                tracks the expected contents; outputs are compared every
//                cycle and the drained stream is pinned to literal values.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_gcd_result_fifo;

  localparam int DEPTH = 4;
  localparam int DW    = 16;
  localparam int CW    = $clog2(DEPTH + 1);

  logic          clk;
  logic          reset;
  logic          io_in_valid;
  logic [DW-1:0] io_in_data;
  logic          io_out_valid;
  logic          io_out_ready;
  logic [DW-1:0] io_out_data;
  logic [CW-1:0] io_count;
  logic          io_full;
  logic          io_overflow;
  logic          io_clear_overflow;

  int tests;
  int fails;

  gcd_result_fifo #(.DEPTH(DEPTH), .DATA_WIDTH(DW)) dut (
    .clk               (clk),
    .reset             (reset),
    .io_in_valid       (io_in_valid),
    .io_in_data        (io_in_data),
    .io_out_valid      (io_out_valid),
    .io_out_ready      (io_out_ready),
    .io_out_data       (io_out_data),
    .io_count          (io_count),
    .io_full           (io_full),
    .io_overflow       (io_overflow),
    .io_clear_overflow (io_clear_overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  logic [DW-1:0] mq[$];
  logic          m_ovf;
  logic          m_live;
  logic          m_popped;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      mq.delete();
      m_ovf    = 1'b0;
      m_live   = 1'b0;
      m_popped = 1'b0;
    end else if (!m_live) begin
      // First edge after release is still part of reset.
      m_live   = 1'b1;
      m_popped = 1'b0;
    end else begin
      bit was_full;
      bit do_pop;
      bit do_push;
      was_full = (mq.size() == DEPTH);
      do_pop   = (mq.size() != 0) && io_out_ready;
      do_push  = io_in_valid && (!was_full || do_pop);
      if (do_pop) void'(mq.pop_front());
      if (do_push) mq.push_back(io_in_data);
      if (io_in_valid && !do_push) m_ovf = 1'b1;
      else if (io_clear_overflow)  m_ovf = 1'b0;
      m_popped = do_pop;
    end
  end

  // ---------------- per-cycle compare ----------------
  logic [DW-1:0] held_data;
  logic [DW-1:0] drain[$];

  always @(posedge clk) begin
    #1;
    tests++;
    if (io_out_valid !== (mq.size() != 0) || io_count !== CW'(mq.size()) ||
        io_full !== (mq.size() == DEPTH) || io_overflow !== m_ovf ||
        (mq.size() != 0 && io_out_data !== mq[0])) begin
      fails++;
      $display("FAIL cycle_model t=%0t: valid=%b count=%0d full=%b ovf=%b data=%h, required valid=%b count=%0d full=%b ovf=%b data=%h",
               $time, io_out_valid, io_count, io_full, io_overflow, io_out_data,
               (mq.size() != 0), mq.size(), (mq.size() == DEPTH), m_ovf,
               (mq.size() != 0) ? mq[0] : 16'h0);
    end
    if (m_popped) drain.push_back(held_data);
    held_data = io_out_data;
  end

  // ---------------- helpers ----------------
  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic step(input logic v, input logic [DW-1:0] d, input logic r, input logic clr);
    @(negedge clk);
    io_in_valid       = v;
    io_in_data        = d;
    io_out_ready      = r;
    io_clear_overflow = clr;
    @(posedge clk);
    #2;
  endtask

  task automatic chk_drain(input string name, input int idx, input int exp);
    if (idx < drain.size()) chk(name, int'(drain[idx]), exp);
    else chk({name, "_missing"}, drain.size(), idx + 1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    tests = 0;
    fails = 0;
    reset = 1'b0;
    io_in_valid = 1'b0;
    io_in_data = '0;
    io_out_ready = 1'b0;
    io_clear_overflow = 1'b0;

    // T1: pulses while reset held are ignored
    step(1, 16'h0011, 0, 0);
    step(1, 16'h0022, 1, 0);
    step(1, 16'h0033, 0, 0);
    chk("t1_valid", io_out_valid, 0);
    chk("t1_count", io_count, 0);
    chk("t1_ovf",   io_overflow, 0);

    // Release: push on first edge is ignored, second edge is accepted
    @(negedge clk);
    reset = 1'b1;
    io_in_valid = 1'b1;
    io_in_data  = 16'h1111;
    @(posedge clk); #2;
    step(1, 16'h2222, 0, 0);
    step(0, 16'h0000, 0, 0);
    chk("rel_count", io_count, 1);
    chk("rel_head",  io_out_data, 16'h2222);
    step(0, 16'h0000, 1, 0);
    chk("rel_empty", io_out_valid, 0);

    // T2: ordering
    drain.delete();
    step(1, 16'h0006, 0, 0);
    step(1, 16'h0015, 0, 0);
    step(1, 16'h0001, 0, 0);
    chk("t2_count", io_count, 3);
    for (int i = 0; i < 3; i++) step(0, 16'h0, 1, 0);
    step(0, 16'h0, 0, 0);
    chk_drain("t2_d0", 0, 16'h0006);
    chk_drain("t2_d1", 1, 16'h0015);
    chk_drain("t2_d2", 2, 16'h0001);
    chk("t2_empty", io_count, 0);

    // T3: overflow, set-wins, clear
    drain.delete();
    for (int i = 0; i < 5; i++) step(1, DW'(16'h000A + i), 0, 0);
    chk("t3_count", io_count, 4);
    chk("t3_full",  io_full, 1);
    chk("t3_ovf",   io_overflow, 1);
    step(1, 16'h0077, 0, 1);
    chk("t3_setwins", io_overflow, 1);
    step(0, 16'h0, 0, 1);
    chk("t3_clear", io_overflow, 0);
    for (int i = 0; i < 4; i++) step(0, 16'h0, 1, 0);
    step(0, 16'h0, 0, 0);
    chk("t3_drain_n", drain.size(), 4);
    chk_drain("t3_d0", 0, 16'h000A);
    chk_drain("t3_d3", 3, 16'h000D);

    // T4: full + push + pop
    drain.delete();
    for (int i = 0; i < 4; i++) step(1, DW'(16'h0021 + i), 0, 0);
    step(1, 16'h00AA, 1, 0);
    chk("t4_count", io_count, 4);
    chk("t4_ovf",   io_overflow, 0);
    for (int i = 0; i < 4; i++) step(0, 16'h0, 1, 0);
    step(0, 16'h0, 0, 0);
    chk_drain("t4_d0", 0, 16'h0021);
    chk_drain("t4_d1", 1, 16'h0022);
    chk_drain("t4_last", 4, 16'h00AA);

    // T5: continuous push/pop with wrap; includes empty + push + ready
    drain.delete();
    for (int i = 0; i < 10; i++) begin
      step(1, DW'(16'h0100 + i), 1, 0);
      chk("t5_count1", io_count, 1);
      step(0, 16'h0, 1, 0);
      chk("t5_count0", io_count, 0);
    end
    chk("t5_drain_n", drain.size(), 10);
    for (int i = 0; i < 10; i++) chk_drain("t5_d", i, 16'h0100 + i);

    // T6: mid-operation reset
    drain.delete();
    step(1, 16'h0031, 0, 0);
    step(1, 16'h0032, 0, 0);
    step(1, 16'h0033, 0, 0);
    step(0, 16'h0, 0, 0);
    chk("t6_pre", io_count, 3);
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    chk("t6_count", io_count, 0);
    chk("t6_valid", io_out_valid, 0);
    @(negedge clk);
    reset = 1'b1;
    step(0, 16'h0, 0, 0);
    step(1, 16'h0044, 0, 0);
    step(0, 16'h0, 1, 0);
    step(0, 16'h0, 0, 0);
    chk("t6_n", drain.size(), 1);
    chk_drain("t6_first", 0, 16'h0044);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
